// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a five-state bus read sequencer with jump and interrupt redirection.
// Optional bus timeout is enabled by defining IFETCH_TIMEOUT_EN.
module instruction_fetch #(
  parameter logic [26:0] RESET_VECTOR   = 27'd0,
  parameter logic [26:0] INT_VECTOR     = 27'd1,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        next_req,
  input  logic        jump_valid,
  input  logic [26:0] jump_addr,
  input  logic        int_req,
  input  logic [31:0] bus_data,
  input  logic        bus_done,
  output logic [26:0] bus_addr,
  output logic        bus_start,
  output logic [31:0] q,
  output logic        fetch,
  output logic        getRegs,
  output logic [26:0] pc,
  output logic [26:0] ret_pc,
  output logic        int_ack,
  output logic        busy,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DELIVER, REGS} state_t;

  state_t      state_reg, state_next;
  logic [26:0] pc_reg, ret_pc_reg, bus_addr_reg;
  logic [31:0] q_reg;
  logic [26:0] fetch_pc;
  logic        sel_int;
  logic        timeout;

  // Jump beats interrupt; a losing interrupt stays pending because int_req is a level.
  assign sel_int  = (state_reg == IDLE) && next_req && !jump_valid && int_req;
  assign fetch_pc = jump_valid ? jump_addr : (int_req ? INT_VECTOR : pc_reg);

`ifdef IFETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_reg;
  logic          fault_reg;

  assign timeout = (state_reg == WAIT) && !bus_done && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= timeout;
      if (state_reg == WAIT && !bus_done && !timeout)
        cnt_reg <= cnt_reg + CW'(1);
      else
        cnt_reg <= '0;
    end
  end

  assign fetch_fault = fault_reg;
`else
  assign timeout     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (next_req) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT: begin
        if (bus_done)
          state_next = DELIVER;
        else if (timeout)
          state_next = IDLE;
      end
      DELIVER: state_next = REGS;
      REGS:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // bus_addr doubles as the in-flight fetch PC, so the increment uses it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_VECTOR;
      ret_pc_reg   <= '0;
      bus_addr_reg <= '0;
      q_reg        <= '0;
    end else begin
      if (state_reg == IDLE && next_req)
        bus_addr_reg <= fetch_pc;
      if (sel_int)
        ret_pc_reg <= pc_reg;
      if (state_reg == WAIT) begin
        if (bus_done) begin
          q_reg  <= bus_data;
          pc_reg <= bus_addr_reg + 27'd1;
        end else if (timeout) begin
          q_reg <= '0;
        end
      end
    end
  end

  always_comb begin
    bus_start = (state_reg == REQ);
    fetch     = (state_reg == DELIVER);
    getRegs   = (state_reg == REGS);
    busy      = (state_reg != IDLE);
    int_ack   = sel_int && !reset;
  end

  assign bus_addr = bus_addr_reg;
  assign q        = q_reg;
  assign pc       = pc_reg;
  assign ret_pc   = ret_pc_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, reset/timeout sequences,
// and randomized fetches checked against a transaction-level PC/interrupt model.
module tb_instruction_fetch;

  localparam logic [26:0] RV = 27'd0;
  localparam logic [26:0] IV = 27'd1;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next_req = 1'b0;
  logic        jump_valid = 1'b0;
  logic [26:0] jump_addr = '0;
  logic        int_req = 1'b0;
  logic [31:0] bus_data = '0;
  logic        bus_done = 1'b0;
  logic [26:0] bus_addr;
  logic        bus_start;
  logic [31:0] q;
  logic        fetch;
  logic        getRegs;
  logic [26:0] pc;
  logic [26:0] ret_pc;
  logic        int_ack;
  logic        busy;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_VECTOR(RV), .INT_VECTOR(IV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .next_req(next_req), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .int_req(int_req), .bus_data(bus_data), .bus_done(bus_done),
    .bus_addr(bus_addr), .bus_start(bus_start), .q(q), .fetch(fetch), .getRegs(getRegs),
    .pc(pc), .ret_pc(ret_pc), .int_ack(int_ack), .busy(busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jv;
    logic [26:0] ja;
    logic        ir;
    logic [31:0] data;
    int          dly;
    logic [26:0] e_addr;
    logic        e_ack;
    logic [26:0] e_pc;
    logic [26:0] e_ret;
  } vec_t;

  vec_t vecs[5];

  logic [26:0] m_pc, m_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete fetch; noise drives ignored next_req/jump_valid during WAIT.
  task automatic do_fetch(input vec_t v, input logic noise);
    @(negedge clk);
    next_req = 1'b1; jump_valid = v.jv; jump_addr = v.ja; int_req = v.ir;
    #1 check("int_ack", 32'(int_ack), 32'(v.e_ack));
    @(negedge clk);
    next_req = 1'b0; jump_valid = 1'b0;
    check("bus_start", 32'(bus_start), 32'd1);
    check("bus_addr", 32'(bus_addr), 32'(v.e_addr));
    check("ret_pc", 32'(ret_pc), 32'(v.e_ret));
    for (int i = 0; i <= v.dly; i++) begin
      @(negedge clk);
      check("wait_no_fetch", 32'({bus_start, fetch, busy}), 32'b001);
      if (noise) begin
        next_req = 1'($urandom_range(0, 1));
        jump_valid = 1'($urandom_range(0, 1));
        jump_addr = 27'($urandom);
      end
      bus_done = (i == v.dly);
      bus_data = (i == v.dly) ? v.data : $urandom;
    end
    @(negedge clk);
    bus_done = 1'b0; next_req = 1'b0; jump_valid = 1'b0;
    check("fetch", 32'(fetch), 32'd1);
    check("q", q, v.data);
    check("pc", 32'(pc), 32'(v.e_pc));
    @(negedge clk);
    check("getRegs", 32'({getRegs, fetch}), 32'b10);
    @(negedge clk);
    check("idle", 32'({busy, getRegs}), 32'b00);
    check("bus_addr_hold", 32'(bus_addr), 32'(v.e_addr));
    int_req = 1'b0;
    $display("fetch addr=%h data=%h pc=%h ret_pc=%h int_ack_exp=%0d", v.e_addr, v.data, pc, ret_pc, v.e_ack);
  endtask

  initial begin
    vecs[0] = '{1'b0, 27'h0,       1'b0, 32'h1234ABCD, 0, 27'h0,       1'b0, 27'h1,   27'h0};
    vecs[1] = '{1'b1, 27'h7FFFFFF, 1'b0, 32'hAAAA5555, 1, 27'h7FFFFFF, 1'b0, 27'h0,   27'h0};
    vecs[2] = '{1'b1, 27'h100,     1'b1, 32'h11111111, 0, 27'h100,     1'b0, 27'h101, 27'h0};
    vecs[3] = '{1'b0, 27'h0,       1'b1, 32'h22222222, 2, IV,          1'b1, IV + 27'd1, 27'h101};
    vecs[4] = '{1'b0, 27'h0,       1'b0, 32'h33333333, 0, IV + 27'd1,  1'b0, IV + 27'd2, 27'h101};

    @(negedge clk);
    check("rst_pc", 32'(pc), 32'(RV));
    check("rst_q", q, 32'h0);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    check("rst_ret_pc", 32'(ret_pc), 32'h0);
    check("rst_strobes", 32'({busy, bus_start, fetch, getRegs, int_ack, fetch_fault}), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) do_fetch(vecs[i], 1'b0);

    // Reset while in WAIT aborts; a late bus_done must not revive the fetch.
    @(negedge clk); next_req = 1'b1;
    @(negedge clk); next_req = 1'b0;
    @(negedge clk); check("rst_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1 check("async_rst", 32'({busy, pc}), 32'(RV));
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    @(negedge clk); bus_done = 1'b1; bus_data = 32'hDEADBEEF;
    @(negedge clk); bus_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_abort", 32'({fetch, getRegs, busy}), 32'h0);
      @(negedge clk);
    end
    check("rst_abort_q", q, 32'h0);
    $display("reset-in-wait q=%h pc=%h busy=%0d", q, pc, busy);

    m_pc = RV;
    m_ret = '0;
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.jv = ($urandom_range(0, 3) == 0);
      v.ja = ($urandom_range(0, 7) == 0) ? 27'h7FFFFFF : 27'($urandom);
      v.ir = ($urandom_range(0, 2) == 0);
      v.data = $urandom;
      v.dly = $urandom_range(0, 3);
      v.e_addr = v.jv ? v.ja : (v.ir ? IV : m_pc);
      v.e_ack = !v.jv && v.ir;
      if (v.e_ack) m_ret = m_pc;
      m_pc = 27'((32'(v.e_addr) + 32'd1) % 32'h8000000);
      v.e_pc = m_pc;
      v.e_ret = m_ret;
      do_fetch(v, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        jump_valid = 1'b1; jump_addr = 27'($urandom); bus_done = 1'b1; int_req = 1'b1;
        @(negedge clk);
        jump_valid = 1'b0; bus_done = 1'b0; int_req = 1'b0;
        check("idle_ignore", 32'({busy, int_ack, pc}), 32'(m_pc));
      end
    end

    // Bus that never answers.
    @(negedge clk); next_req = 1'b1;
    @(negedge clk); next_req = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_wait", 32'({busy, fetch_fault}), 32'b10);
    end
    @(negedge clk);
    check("to_fault", 32'({fetch_fault, busy, fetch, getRegs}), 32'b1000);
    check("to_pc", 32'(pc), 32'(m_pc));
    check("to_q", q, 32'h0);
    @(negedge clk);
    check("to_pulse", 32'(fetch_fault), 32'd0);
`else
    for (int i = 0; i < 40; i++) @(negedge clk);
    check("no_to_busy", 32'({busy, fetch_fault}), 32'b10);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
`endif
    $display("timeout pc=%h busy=%0d fault=%0d", pc, busy, fetch_fault);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
